sic_core_mc: RTL and testbench

- Parametrised multi-cycle SIC processor core and the successor to the first fixed-timing SIC CPU.
- Adds a memory request/ready handshake (arbitrary wait states), separate operand-read and write phases, and indexed effective addressing.
- Implements the full SIC integer instruction subset, including conditional jumps and subroutine linkage, plus trap/halt on illegal opcode or divide-by-zero.
- Sits between the instruction/data memory model and the debug/test harness.

---
 rtl/sic_core_mc.sv | 205 ++++++++++++++++++++
 tb/tb_sic_core_mc.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sic_core_mc.sv
// Multi-cycle SIC core with a req/ready memory handshake, indexed addressing and trap-on-fault halt.
// Each instruction goes FETCH -> DECODE -> (MEM_RD -> EXEC | MEM_WR | EXEC) -> FETCH, and one memory access completes per phase.
module sic_core_mc #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH = 24,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ready,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [1:0]               cc,
  output logic                     halted,
  output logic [1:0]               trap_code,
  output logic [ADDRESS_WIDTH-1:0] pc_dbg
);

  localparam logic [7:0] OP_LDA  = 8'h00, OP_LDX  = 8'h04, OP_LDL = 8'h08;
  localparam logic [7:0] OP_STA  = 8'h0C, OP_STX  = 8'h10, OP_STL = 8'h14;
  localparam logic [7:0] OP_ADD  = 8'h18, OP_SUB  = 8'h1C, OP_MUL = 8'h20, OP_DIV = 8'h24;
  localparam logic [7:0] OP_COMP = 8'h28, OP_TIX  = 8'h2C;
  localparam logic [7:0] OP_JEQ  = 8'h30, OP_JGT  = 8'h34, OP_JLT = 8'h38, OP_J = 8'h3C;
  localparam logic [7:0] OP_AND  = 8'h40, OP_OR   = 8'h44;
  localparam logic [7:0] OP_JSUB = 8'h48, OP_RSUB = 8'h4C;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR, S_EXEC, S_HALT
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, ea_q, ea_d;
  logic [DATA_WIDTH-1:0]    ir_q, ir_d, opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0]    a_q, a_d, x_q, x_d, l_q, l_d;
  logic [1:0]               cc_q, cc_d, trap_q, trap_d;
  logic                     halted_q, halted_d;

  logic [7:0]               op_byte;
  logic [ADDRESS_WIDTH-1:0] addr_field, ea_calc;
  logic [DATA_WIDTH-1:0]    x_inc, quot, store_data;
  logic                     unused_bits;

  // Opcode is the top six bits of the first instruction byte; IR[17:16] carry no meaning.
  assign op_byte     = {ir_q[23:18], 2'b00};
  assign unused_bits = ^ir_q[17:16];
  assign addr_field  = ADDRESS_WIDTH'(ir_q[14:0]);
  assign ea_calc     = ir_q[15] ? addr_field + x_q[ADDRESS_WIDTH-1:0] : addr_field;
  assign x_inc       = x_q + DATA_WIDTH'(1);
  assign quot        = (opnd_q == '0) ? '0 : DATA_WIDTH'($signed(a_q) / $signed(opnd_q));

  function automatic logic [1:0] cmp_cc(input logic [DATA_WIDTH-1:0] lhs, input logic [DATA_WIDTH-1:0] rhs);
    if ($signed(lhs) < $signed(rhs)) return 2'b01;
    if ($signed(lhs) > $signed(rhs)) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    store_data = a_q;
    if (op_byte == OP_STX) store_data = x_q;
    else if (op_byte == OP_STL) store_data = l_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ea_q     <= '0;
      ir_q     <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      x_q      <= '0;
      l_q      <= '0;
      cc_q     <= 2'b00;
      trap_q   <= 2'b00;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ea_q     <= ea_d;
      ir_q     <= ir_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      x_q      <= x_d;
      l_q      <= l_d;
      cc_q     <= cc_d;
      trap_q   <= trap_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ea_d      = ea_q;
    ir_d      = ir_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    x_d       = x_q;
    l_d       = l_q;
    cc_d      = cc_q;
    trap_d    = trap_q;
    halted_d  = halted_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDRESS_WIDTH'(3);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ea_d = ea_calc;
        case (op_byte)
          OP_LDA, OP_LDX, OP_LDL, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
          OP_COMP, OP_TIX, OP_AND, OP_OR:                  state_d = S_MEM_RD;
          OP_STA, OP_STX, OP_STL:                           state_d = S_MEM_WR;
          OP_JEQ, OP_JGT, OP_JLT, OP_J, OP_JSUB, OP_RSUB:   state_d = S_EXEC;
          default: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            trap_d   = 2'b01;
          end
        endcase
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = ea_q;
        if (mem_ready) begin
          opnd_d  = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ea_q;
        mem_wdata = store_data;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_byte)
          OP_LDA:  a_d = opnd_q;
          OP_LDX:  x_d = opnd_q;
          OP_LDL:  l_d = opnd_q;
          OP_ADD:  a_d = a_q + opnd_q;
          OP_SUB:  a_d = a_q - opnd_q;
          OP_MUL:  a_d = a_q * opnd_q;
          OP_DIV: begin
            if (opnd_q == '0) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              trap_d   = 2'b10;
            end else begin
              a_d = quot;
            end
          end
          OP_COMP: cc_d = cmp_cc(a_q, opnd_q);
          OP_TIX: begin
            x_d  = x_inc;
            cc_d = cmp_cc(x_inc, opnd_q);
          end
          OP_AND:  a_d = a_q & opnd_q;
          OP_OR:   a_d = a_q | opnd_q;
          OP_JEQ:  if (cc_q == 2'b00) pc_d = ea_q;
          OP_JGT:  if (cc_q == 2'b10) pc_d = ea_q;
          OP_JLT:  if (cc_q == 2'b01) pc_d = ea_q;
          OP_J:    pc_d = ea_q;
          OP_JSUB: begin
            l_d  = DATA_WIDTH'(pc_q);
            pc_d = ea_q;
          end
          OP_RSUB: pc_d = l_q[ADDRESS_WIDTH-1:0];
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    // The bus goes quiet as soon as reset is raised, without waiting for a clock edge.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  assign cc        = cc_q;
  assign halted    = halted_q;
  assign trap_code = trap_q;
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_sic_core_mc.sv
// Self-checking bench for sic_core_mc: memory responder with wait states, write scoreboard,
// table-driven ALU/compare vectors and hand sequences for timing, indexing, jumps, traps and reset.
module tb_sic_core_mc;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ready;
  logic [14:0] mem_addr, pc_dbg;
  logic [23:0] mem_wdata, mem_rdata;
  logic [1:0]  cc, trap_code;
  logic        halted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int wr_cyc = 0;
  int wait_n = 0;
  int wcnt = 0;
  bit pend = 0;
  logic [14:0] p_addr;
  logic        p_we;
  logic [23:0] p_wdata;
  logic [23:0] mem [0:32767];

  typedef struct packed {
    logic [14:0] addr;
    logic [23:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [7:0]  opc;
    logic [23:0] a_init;
    logic [23:0] opnd;
    logic [23:0] exp_a;
    logic [1:0]  exp_cc;
  } vec_t;
  vec_t vecs[17];

  sic_core_mc dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cc(cc), .halted(halted), .trap_code(trap_code), .pc_dbg(pc_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) mem[i] = 24'hFC0000;
  endtask

  task automatic push_wr(input logic [14:0] a, input logic [23:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Memory model: decides ready/rdata half a cycle before each rising edge.
  task automatic responder();
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (pend) begin
          check("hold_addr", 32'(mem_addr), 32'(p_addr));
          check("hold_we", 32'(mem_we), 32'(p_we));
          check("hold_wdata", 32'(mem_wdata), 32'(p_wdata));
        end
        pend = 1;
        p_addr = mem_addr;
        p_we = mem_we;
        p_wdata = mem_wdata;
        if (wcnt >= wait_n) begin
          mem_ready = 1'b1;
          pend = 0;
          wcnt = 0;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_cyc = cyc + 1 - rel_cyc;
            $display("write addr=%h data=%h cycle=%0d", mem_addr, mem_wdata, wr_cyc);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
            end else begin
              e = exp_q.pop_front();
              check("wr_addr", 32'(mem_addr), 32'(e.addr));
              check("wr_data", 32'(mem_wdata), 32'(e.data));
            end
            mem_rdata = 24'($urandom);
          end else begin
            mem_rdata = mem[mem_addr];
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 24'($urandom);
          wcnt++;
        end
      end else begin
        pend = 0;
        wcnt = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = 24'($urandom);
      end
    end
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic at_cycle(input int k);
    int guard = 0;
    while ((cyc - rel_cyc) < k && guard < 1000) begin
      @(posedge clk);
      #2;
      guard++;
    end
  endtask

  task automatic run_until_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    clear_mem();

    vecs[0]  = '{8'h18, 24'h000005, 24'hFFFFFE, 24'h000003, 2'b00};
    vecs[1]  = '{8'h1C, 24'h000005, 24'h000007, 24'hFFFFFE, 2'b00};
    vecs[2]  = '{8'h20, 24'h000123, 24'h000100, 24'h012300, 2'b00};
    vecs[3]  = '{8'h20, 24'h400000, 24'h000004, 24'h000000, 2'b00};
    vecs[4]  = '{8'h20, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 2'b00};
    vecs[5]  = '{8'h24, 24'hFFFFF9, 24'h000002, 24'hFFFFFD, 2'b00};
    vecs[6]  = '{8'h24, 24'h000007, 24'hFFFFFE, 24'hFFFFFD, 2'b00};
    vecs[7]  = '{8'h24, 24'h000064, 24'h000007, 24'h00000E, 2'b00};
    vecs[8]  = '{8'h40, 24'hF0F0F0, 24'h0FF0FF, 24'h00F0F0, 2'b00};
    vecs[9]  = '{8'h44, 24'hF0F0F0, 24'h0FF0FF, 24'hFFF0FF, 2'b00};
    vecs[10] = '{8'h28, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 2'b01};
    vecs[11] = '{8'h28, 24'h000005, 24'h000005, 24'h000005, 2'b00};
    vecs[12] = '{8'h28, 24'h000001, 24'hFFFFFF, 24'h000001, 2'b10};
    vecs[13] = '{8'h2C, 24'h000009, 24'h000001, 24'h000009, 2'b00};
    vecs[14] = '{8'h2C, 24'h000009, 24'h000000, 24'h000009, 2'b10};
    vecs[15] = '{8'h2C, 24'h000009, 24'h000005, 24'h000009, 2'b01};
    vecs[16] = '{8'h00, 24'h000009, 24'h123456, 24'h123456, 2'b00};

    fork
      responder();
    join_none

    // Outputs while reset is held.
    repeat (2) @(negedge clk);
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_trap", 32'(trap_code), 32'd0);
    check("rst_cc", 32'(cc), 32'd0);
    check("rst_pc", 32'(pc_dbg), 32'd0);

    // Zero-wait LDA then ADD (with the ignored IR[17:16] bits set): cycle-exact PC progression.
    clear_mem();
    wait_n = 0;
    mem[0] = 24'h000100;
    mem[3] = 24'h1B0103;
    mem[6] = 24'h0C0200;
    mem[15'h100] = 24'h000005;
    mem[15'h103] = 24'hFFFFFE;
    push_wr(15'h200, 24'h000003);
    restart();
    at_cycle(4);
    check("t0_pc_c4", 32'(pc_dbg), 32'h3);
    at_cycle(8);
    check("t0_pc_c8", 32'(pc_dbg), 32'h6);
    run_until_halt(100);
    check("t0_wr_cycle", 32'(wr_cyc), 32'd11);
    check("t0_trap", 32'(trap_code), 32'd1);
    check("t0_pc_end", 32'(pc_dbg), 32'hC);
    check("t0_q_empty", 32'(exp_q.size()), 32'd0);

    // Same program with three wait cycles on every access.
    wait_n = 3;
    push_wr(15'h200, 24'h000003);
    mem[15'h200] = 24'hFC0000;
    restart();
    at_cycle(10);
    check("t1_pc_c10", 32'(pc_dbg), 32'h3);
    at_cycle(14);
    check("t1_pc_c14", 32'(pc_dbg), 32'h6);
    run_until_halt(200);
    check("t1_wr_cycle", 32'(wr_cyc), 32'd29);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Table of single-ALU-op programs: LDA, <op>, STA 0x200, illegal opcode.
    for (int i = 0; i < 17; i++) begin
      clear_mem();
      wait_n = i % 3;
      mem[0] = 24'h000100;
      mem[3] = {vecs[i].opc, 16'h0103};
      mem[6] = 24'h0C0200;
      mem[15'h100] = vecs[i].a_init;
      mem[15'h103] = vecs[i].opnd;
      push_wr(15'h200, vecs[i].exp_a);
      restart();
      run_until_halt(200);
      $display("vector %0d opc=%h a=%h operand=%h cc=%b", i, vecs[i].opc, vecs[i].a_init, vecs[i].opnd, cc);
      check("vec_trap", 32'(trap_code), 32'd1);
      check("vec_cc", 32'(cc), 32'(vecs[i].exp_cc));
      check("vec_pc", 32'(pc_dbg), 32'hC);
      check("vec_q_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end

    // Indexed stores, including EA wrap past the top of the address space.
    clear_mem();
    wait_n = 0;
    mem[0]  = 24'h040100;
    mem[3]  = 24'h000103;
    mem[6]  = 24'h0C8100;
    mem[9]  = 24'h0CFFFE;
    mem[15'h100] = 24'h000006;
    mem[15'h103] = 24'hABCDEF;
    push_wr(15'h106, 24'hABCDEF);
    push_wr(15'h004, 24'hABCDEF);
    restart();
    run_until_halt(100);
    check("idx_pc", 32'(pc_dbg), 32'hF);
    check("idx_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Conditional jumps, JSUB/RSUB linkage.
    clear_mem();
    wait_n = 1;
    mem[0]        = 24'h000100;
    mem[3]        = 24'h280103;
    mem[6]        = 24'h340050;
    mem[9]        = 24'h380200;
    mem[15'h200]  = 24'h300060;
    mem[15'h203]  = 24'h0C0180;
    mem[15'h206]  = 24'h3C0030;
    mem[15'h030]  = 24'h480300;
    mem[15'h300]  = 24'h140190;
    mem[15'h303]  = 24'h4C0000;
    mem[15'h100]  = 24'hFFFFFF;
    mem[15'h103]  = 24'h000001;
    push_wr(15'h180, 24'hFFFFFF);
    push_wr(15'h190, 24'h000033);
    restart();
    run_until_halt(300);
    check("jmp_pc", 32'(pc_dbg), 32'h36);
    check("jmp_cc", 32'(cc), 32'd1);
    check("jmp_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Divide by zero traps with A untouched and the bus idle.
    clear_mem();
    wait_n = 0;
    mem[0] = 24'h000100;
    mem[3] = 24'h240103;
    mem[15'h100] = 24'h000005;
    mem[15'h103] = 24'h000000;
    restart();
    run_until_halt(100);
    check("div0_trap", 32'(trap_code), 32'd2);
    check("div0_pc", 32'(pc_dbg), 32'h6);
    check("div0_a", 32'(dut.a_q), 32'h5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #2;
      check("div0_req_idle", 32'(mem_req), 32'd0);
    end
    check("div0_halted", 32'(halted), 32'd1);

    // Reset asserted while a data read is stalled.
    clear_mem();
    wait_n = 1;
    mem[0] = 24'h000100;
    mem[3] = 24'h280103;
    mem[6] = 24'h000106;
    mem[15'h100] = 24'hFFFFFF;
    mem[15'h103] = 24'h000001;
    restart();
    begin
      int n = 0;
      while (!(mem_req && !mem_we && mem_addr == 15'h106 && pc_dbg == 15'h9) && n < 100) begin
        @(negedge clk);
        #2;
        n++;
      end
      check("rmw_reached", 32'(n < 100), 32'd1);
    end
    check("rmw_cc_before", 32'(cc), 32'd1);
    rst = 1'b1;
    #1;
    check("rmw_req", 32'(mem_req), 32'd0);
    check("rmw_addr", 32'(mem_addr), 32'd0);
    check("rmw_we", 32'(mem_we), 32'd0);
    check("rmw_wdata", 32'(mem_wdata), 32'd0);
    check("rmw_cc", 32'(cc), 32'd0);
    check("rmw_pc", 32'(pc_dbg), 32'd0);
    check("rmw_halted", 32'(halted), 32'd0);
    check("rmw_trap", 32'(trap_code), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    check("rmw_req_held", 32'(mem_req), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
